// File: rtl/rkv_i2c_master_byte_engine.sv
// ---------------------------------------------------------------------------
// rkv_i2c_master_byte_engine
//
// Byte-level I2C master bus engine. Each accepted command moves one byte on
// the bus: an optional START or repeated START, 8 data bits MSB first, the ACK
// bit, then either a STOP or a HOLD with SCL parked low until the next command.
// Each phase (START, every bit, STOP) is four quarters Q0..Q3. A quarter lasts
// max(scl_div,4)+1 pclk cycles. The engine supports slave clock stretching and
// detects loss of multi-master arbitration.
//
// Ports
//   pclk, presetn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE or HOLD)
//   cmd_start/cmd_stop   (repeated) START before the byte / STOP after the ACK
//   cmd_read, cmd_nack   read byte; ACK-bit value driven on a read (1 = NACK)
//   cmd_wdata            byte to write
//   scl_div              quarter-period divider, captured when a command is accepted
//   rsp_valid            one-cycle pulse when a byte is finished or arbitration is lost
//   rsp_rdata/nack/arb   response fields, held until the next rsp_valid
//   busy                 engine not idle
//   scl_oe, sda_oe       open-drain pull-down enables (1 = drive low)
//   scl_i, sda_i         synchronised pad levels
// ---------------------------------------------------------------------------
module rkv_i2c_master_byte_engine #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_read,
  input  logic             cmd_nack,
  input  logic [7:0]       cmd_wdata,
  input  logic [DIV_W-1:0] scl_div,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_nack,
  output logic             rsp_arb,
  output logic             busy,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_HOLD} state_t;

  localparam logic [DIV_W-1:0] QMAX_MIN = DIV_W'(4);

  state_t           state_reg, state_next;
  logic [1:0]       quarter_reg, quarter_next;
  logic [DIV_W-1:0] qcnt_reg, qcnt_next;
  logic [DIV_W-1:0] qmax_reg, qmax_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             read_reg, read_next;
  logic             nack_reg, nack_next;
  logic             stop_reg, stop_next;
  logic             from_hold_reg, from_hold_next;
  logic             ack_reg, ack_next;
  logic             ready_reg, ready_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [7:0]       rsp_rdata_reg, rsp_rdata_next;
  logic             rsp_nack_reg, rsp_nack_next;
  logic             rsp_arb_reg, rsp_arb_next;

  logic             accept;
  logic             stretch;
  logic             q_last;
  logic             phase_end;
  logic             first_q2;
  logic             arb;
  logic             bit_drive;
  logic [DIV_W-1:0] qmax_new;

  // The quarter counter loads Q-1 and counts down to zero.
  assign qmax_new  = (scl_div < QMAX_MIN) ? QMAX_MIN : scl_div;
  assign accept    = cmd_valid && ready_reg;
  // A slave holding SCL low during Q1 freezes the counter.
  assign stretch   = (quarter_reg == 2'd1) && !scl_i;
  assign q_last    = (qcnt_reg == '0);
  assign phase_end = !stretch && q_last && (quarter_reg == 2'd3);
  // Q2 never stalls, so a full counter in Q2 marks its first cycle.
  assign first_q2  = (quarter_reg == 2'd2) && (qcnt_reg == qmax_reg);

  // SDA drive during a bit phase. Data bits drive the write byte, or release
  // the line for a read. The ACK bit drives ACK or NACK on a read and
  // releases the line on a write.
  assign bit_drive = bit_cnt_reg[3] ? (read_reg && !nack_reg)
                                    : (!read_reg && !shift_reg[7]);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg     <= S_IDLE;
      quarter_reg   <= 2'd0;
      qcnt_reg      <= '0;
      qmax_reg      <= '0;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'd0;
      read_reg      <= 1'b0;
      nack_reg      <= 1'b0;
      stop_reg      <= 1'b0;
      from_hold_reg <= 1'b0;
      ack_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'd0;
      rsp_nack_reg  <= 1'b0;
      rsp_arb_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      quarter_reg   <= quarter_next;
      qcnt_reg      <= qcnt_next;
      qmax_reg      <= qmax_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      read_reg      <= read_next;
      nack_reg      <= nack_next;
      stop_reg      <= stop_next;
      from_hold_reg <= from_hold_next;
      ack_reg       <= ack_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_nack_reg  <= rsp_nack_next;
      rsp_arb_reg   <= rsp_arb_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    quarter_next   = quarter_reg;
    qcnt_next      = qcnt_reg;
    qmax_next      = qmax_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    read_next      = read_reg;
    nack_next      = nack_reg;
    stop_next      = stop_reg;
    from_hold_next = from_hold_reg;
    ack_next       = ack_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_nack_next  = rsp_nack_reg;
    rsp_arb_next   = rsp_arb_reg;
    arb            = 1'b0;

    // Quarter sequencing shared by all timed phases.
    if (state_reg == S_START || state_reg == S_BIT || state_reg == S_STOP) begin
      if (!stretch) begin
        if (q_last) begin
          quarter_next = quarter_reg + 2'd1;
          qcnt_next    = qmax_reg;
        end else begin
          qcnt_next = qcnt_reg - DIV_W'(1);
        end
      end
    end

    // Load a new command. The divider is captured here and used for the whole byte.
    if (accept) begin
      qmax_next    = qmax_new;
      qcnt_next    = qmax_new;
      quarter_next = 2'd0;
      bit_cnt_next = 4'd0;
      shift_next   = cmd_read ? 8'd0 : cmd_wdata;
      read_next    = cmd_read;
      nack_next    = cmd_nack;
      stop_next    = cmd_stop;
    end

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next     = S_START;
          from_hold_next = 1'b0;
        end
      end
      S_HOLD: begin
        if (accept) begin
          state_next     = cmd_start ? S_START : S_BIT;
          from_hold_next = 1'b1;
        end
      end
      S_START: begin
        // Another master already holds SDA low when we release SCL.
        arb = (quarter_reg == 2'd1) && !sda_i;
        if (phase_end) begin
          state_next   = S_BIT;
          bit_cnt_next = 4'd0;
        end
      end
      S_BIT: begin
        arb = (quarter_reg == 2'd2) && !bit_cnt_reg[3] && !read_reg &&
              shift_reg[7] && !sda_i;
        if (first_q2) begin
          if (bit_cnt_reg[3]) begin
            ack_next = sda_i;
          end else if (read_reg) begin
            shift_next = {shift_reg[6:0], sda_i};
          end
        end
        if (phase_end) begin
          if (bit_cnt_reg[3]) begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = shift_reg;
            rsp_nack_next  = read_reg ? nack_reg : ack_next;
            rsp_arb_next   = 1'b0;
            state_next     = stop_reg ? S_STOP : S_HOLD;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (!read_reg) begin
              shift_next = {shift_reg[6:0], 1'b0};
            end
          end
        end
      end
      S_STOP: begin
        // SDA has been released here, so a low line means another master won.
        arb = quarter_reg[1] && !sda_i;
        if (phase_end) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (arb) begin
      state_next     = S_IDLE;
      rsp_valid_next = 1'b1;
      rsp_arb_next   = 1'b1;
      rsp_nack_next  = 1'b0;
      rsp_rdata_next = shift_reg;
    end

    ready_next = (state_next == S_IDLE) || (state_next == S_HOLD);
  end

  // Pad drive decoded from the registered state, so a reset releases the lines at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_reg)
      S_START: begin
        // After a HOLD, SCL stays low through Q0 of a repeated START.
        scl_oe = (quarter_reg == 2'd0) ? from_hold_reg : (quarter_reg == 2'd3);
        sda_oe = quarter_reg[1];
      end
      S_BIT: begin
        scl_oe = (quarter_reg == 2'd0) || (quarter_reg == 2'd3);
        sda_oe = bit_drive;
      end
      S_STOP: begin
        scl_oe = (quarter_reg == 2'd0);
        sda_oe = !quarter_reg[1];
      end
      S_HOLD: scl_oe = 1'b1;
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign cmd_ready = ready_reg;
  assign busy      = (state_reg != S_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_nack  = rsp_nack_reg;
  assign rsp_arb   = rsp_arb_reg;

endmodule
